uart_receiver: RTL and testbench

- UART receive path; mirrors the transmitter's frame format and configuration encoding, so a TX/RX pair sharing settings interoperates.
- Oversamples the asynchronous rx pin in the clk domain, recovers start/data/parity/stop bits at mid-bit, and presents one received character at a time through a valid/ack holding register.
- Reports parity, framing and overrun errors.

---
 rtl/uart_receiver.sv | 157 +++++++++++++++
 tb/tb_uart_receiver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchronized rx, mid-bit sampling driven by a divisor counter,
// and a single valid/ack holding register carrying data plus parity/frame/overrun flags.
module uart_receiver #(
   parameter int CLOCK_DIVISOR_WIDTH = 24
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rx,
   input  logic [1:0]                     dataBits,
   input  logic                           hasParity,
   input  logic [1:0]                     parityMode,
   input  logic                           extraStopBit,
   input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
   output logic [7:0]                     data,
   output logic                           valid,
   input  logic                           ack,
   output logic                           parityError,
   output logic                           frameError,
   output logic                           overrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2,
      S_DELIVER
   } state_t;

   state_t                         r_state;
   logic                           r_rx_meta;
   logic                           r_rx_sync;
   logic                           r_rx_prev;
   logic [CLOCK_DIVISOR_WIDTH:0]   r_cnt;
   logic [CLOCK_DIVISOR_WIDTH-1:0] r_div;
   logic [1:0]                     r_db;
   logic                           r_has_par;
   logic [1:0]                     r_par_mode;
   logic                           r_two_stop;
   logic [7:0]                     r_shift;
   logic [2:0]                     r_idx;
   logic                           r_par_acc;
   logic                           r_pe;
   logic                           r_fe;

   logic                           w_fall;
   logic                           w_tick;
   logic                           w_start;
   logic                           w_exp_par;
   logic [2:0]                     w_last_idx;

   assign w_fall     = r_rx_prev & ~r_rx_sync;
   assign w_tick     = (r_cnt == '0);
   // DELIVER also watches for a start edge so a frame following at the shortest legal spacing is not missed
   assign w_start    = w_fall && ((r_state == S_IDLE) || (r_state == S_DELIVER));
   assign w_last_idx = {1'b0, r_db} + 3'd4;

   always_comb begin
      w_exp_par = 1'b0;
      case (r_par_mode)
         2'b00:   w_exp_par = 1'b0;
         2'b11:   w_exp_par = 1'b1;
         2'b10:   w_exp_par = r_par_acc;
         default: w_exp_par = ~r_par_acc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rx_meta   <= 1'b1;
         r_rx_sync   <= 1'b1;
         r_rx_prev   <= 1'b1;
         r_cnt       <= '0;
         r_div       <= '0;
         r_db        <= '0;
         r_has_par   <= 1'b0;
         r_par_mode  <= '0;
         r_two_stop  <= 1'b0;
         r_shift     <= '0;
         r_idx       <= '0;
         r_par_acc   <= 1'b0;
         r_pe        <= 1'b0;
         r_fe        <= 1'b0;
         data        <= '0;
         valid       <= 1'b0;
         parityError <= 1'b0;
         frameError  <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;

         // Reload with 2D+1 so consecutive samples are exactly P = 2*(D+1) cycles apart
         if (w_tick) r_cnt <= {r_div, 1'b1};
         else        r_cnt <= r_cnt - 1'b1;

         if (valid && ack) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
         end

         case (r_state)
            S_IDLE: ;
            S_START: if (w_tick) begin
               r_idx   <= '0;
               r_state <= r_rx_sync ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_tick) begin
               r_shift[r_idx] <= r_rx_sync;
               r_par_acc      <= r_par_acc ^ r_rx_sync;
               if (r_idx == w_last_idx) r_state <= r_has_par ? S_PARITY : S_STOP1;
               else                     r_idx   <= r_idx + 3'd1;
            end
            S_PARITY: if (w_tick) begin
               r_pe    <= (r_rx_sync != w_exp_par);
               r_state <= S_STOP1;
            end
            S_STOP1: if (w_tick) begin
               if (!r_rx_sync) r_fe <= 1'b1;
               r_state <= r_two_stop ? S_STOP2 : S_DELIVER;
            end
            S_STOP2: if (w_tick) begin
               if (!r_rx_sync) r_fe <= 1'b1;
               r_state <= S_DELIVER;
            end
            S_DELIVER: begin
               data        <= r_shift;
               parityError <= r_pe;
               frameError  <= r_fe;
               valid       <= 1'b1;
               overrun     <= valid & ~ack;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_start) begin
            r_state    <= S_START;
            r_cnt      <= {1'b0, clockDivisor};
            r_div      <= clockDivisor;
            r_db       <= dataBits;
            r_has_par  <= hasParity;
            r_par_mode <= parityMode;
            r_two_stop <= extraStopBit;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_pe       <= 1'b0;
            r_fe       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames are driven bit by bit, expected characters go into a
// queue, and a monitor pops and compares each character the receiver presents, then acks it.
module tb_uart_receiver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b1;
   logic [1:0]  cfg_db = 2'd3;
   logic        cfg_hp = 1'b0;
   logic [1:0]  cfg_pm = 2'b00;
   logic        cfg_es = 1'b0;
   logic [23:0] cfg_div = 24'd3;
   logic [7:0]  data;
   logic        valid;
   logic        ack = 1'b0;
   logic        parityError;
   logic        frameError;
   logic        overrun;

   int          n_cmp = 0;
   int          n_fail = 0;
   bit          auto_ack = 1'b1;
   logic [10:0] exp_q[$];

   uart_receiver #(.CLOCK_DIVISOR_WIDTH(24)) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .dataBits(cfg_db), .hasParity(cfg_hp), .parityMode(cfg_pm),
      .extraStopBit(cfg_es), .clockDivisor(cfg_div),
      .data(data), .valid(valid), .ack(ack),
      .parityError(parityError), .frameError(frameError), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, got no completion, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: what the receiver should report for one frame, from the frame format rules.
   function automatic logic [10:0] model(input logic [7:0] ch, input logic par_bit,
                                         input logic s1, input logic s2, input logic ov);
      logic [7:0] d;
      logic       ep;
      d = '0;
      for (int i = 0; i < int'(cfg_db) + 5; i++) d[i] = ch[i];
      case (cfg_pm)
         2'b00:   ep = 1'b0;
         2'b11:   ep = 1'b1;
         2'b10:   ep = ^d;
         default: ep = ~^d;
      endcase
      return {ov, (!s1) || (cfg_es && !s2), cfg_hp && (par_bit != ep), d};
   endfunction

   task automatic hold_bit(input logic v, input int p);
      rx = v;
      repeat (p) @(posedge clk);
      #1;
   endtask

   // ack_at > 0 pulses ack for the one cycle sampled at edge ack_at+1 counted from the start-bit edge
   task automatic send_frame(input logic [7:0] ch, input logic par_bit, input logic s1,
                             input logic s2, input bit push, input int ack_at);
      int p;
      int nb;
      p  = 2 * (int'(cfg_div) + 1);
      nb = int'(cfg_db) + 5;
      if (push) exp_q.push_back(model(ch, par_bit, s1, s2, 1'b0));
      @(posedge clk);
      #1;
      fork
         begin
            hold_bit(1'b0, p);
            for (int i = 0; i < nb; i++) hold_bit(ch[i], p);
            if (cfg_hp) hold_bit(par_bit, p);
            hold_bit(s1, p);
            if (cfg_es) hold_bit(s2, p);
            rx = 1'b1;
         end
         begin
            if (ack_at > 0) begin
               repeat (ack_at) @(posedge clk);
               #1 ack = 1'b1;
               @(posedge clk);
               #1 ack = 1'b0;
            end
         end
      join
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d characters outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic manual_ack();
      @(posedge clk);
      #1 ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
   endtask

   task automatic set_cfg(input logic [1:0] db, input logic hp, input logic [1:0] pm,
                          input logic es, input logic [23:0] dv);
      cfg_db = db; cfg_hp = hp; cfg_pm = pm; cfg_es = es; cfg_div = dv;
   endtask

   // Monitor: compare every presented character against the queue head, then ack it.
   initial begin
      logic [10:0] item;
      forever begin
         @(negedge clk);
         if (auto_ack && valid && !rst) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_char: got data %0h, expected no character", data);
            end else begin
               item = exp_q.pop_front();
               chk("rx_char", {21'd0, overrun, frameError, parityError, data}, {21'd0, item});
            end
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            chk("ack_clear", {30'd0, valid, overrun}, 32'd0);
         end
      end
   end

   initial begin
      logic [10:0] m;
      int          at;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_state", {overrun, frameError, parityError, valid, data}, 12'd0);

      // 8N1, D=3
      set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 24'd3);
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 0);
      wait_drain(200);

      // 7 data bits, even then odd parity
      set_cfg(2'd2, 1'b1, 2'b10, 1'b0, 24'd3);
      send_frame(8'h35, 1'b0, 1'b1, 1'b1, 1'b1, 0);
      wait_drain(200);
      send_frame(8'h35, 1'b1, 1'b1, 1'b1, 1'b1, 0);
      wait_drain(200);
      cfg_pm = 2'b01;
      send_frame(8'h35, 1'b1, 1'b1, 1'b1, 1'b1, 0);
      wait_drain(200);

      // 5 data bits, all ones; then a zero second stop bit
      set_cfg(2'd0, 1'b0, 2'b00, 1'b0, 24'd3);
      send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 0);
      wait_drain(200);
      cfg_es = 1'b1;
      send_frame(8'h1F, 1'b0, 1'b1, 1'b0, 1'b1, 0);
      wait_drain(200);

      // Two-cycle glitch is rejected; a real frame follows
      set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 24'd3);
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (2) @(posedge clk);
      #1 rx = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("glitch_no_valid", {31'd0, valid}, 32'd0);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 0);
      wait_drain(200);

      // Overrun, ack release, and deliver coinciding with ack
      auto_ack = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      repeat (3) @(negedge clk);
      m = model(8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("overrun_state", {20'd0, m[10:8], 1'b1, m[7:0]},
          {20'd0, overrun, frameError, parityError, valid, data});
      manual_ack();
      @(negedge clk);
      chk("ack_release", {22'd0, valid, overrun, data}, {22'd0, 2'b00, 8'h22});
      send_frame(8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      @(negedge clk);
      chk("hold_44", {22'd0, valid, overrun, data}, {22'd0, 2'b10, 8'h44});
      at = 3 + (int'(cfg_div) + 1) + 9 * 2 * (int'(cfg_div) + 1);
      send_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b0, at);
      repeat (2) @(negedge clk);
      chk("deliver_with_ack", {22'd0, valid, overrun, data}, {22'd0, 2'b10, 8'h33});
      manual_ack();
      auto_ack = 1'b1;
      repeat (3) @(posedge clk);

      // Reset in the middle of the data bits of 0x55
      @(posedge clk);
      #1;
      hold_bit(1'b0, 8);
      hold_bit(1'b1, 8);
      hold_bit(1'b0, 8);
      hold_bit(1'b1, 8);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_frame_reset", {20'd0, overrun, frameError, parityError, valid, data}, 32'd0);
      repeat (120) @(posedge clk);
      @(negedge clk);
      chk("reset_no_delivery", {31'd0, valid}, 32'd0);
      send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 1'b1, 0);
      wait_drain(200);

      // Randomized frames and configurations
      for (int k = 0; k < 16; k++) begin
         set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 24'($urandom_range(0, 3)));
         repeat (4) @(posedge clk);
         send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b1, 0);
         wait_drain(300);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
